vl6180x_i2c_master: RTL and testbench

- Byte-level I2C master that runs complete VL6180X register transactions: 16-bit register index, 8-bit data, fixed 7-bit device address.
- Sits directly upstream of `top`'s range/LED logic: the sequencer issues one write or read command at a time and consumes `RDATA`/`NACK` when `DONE` pulses.
- Drives the open-drain bus pins through output-enables only.
- No clock stretching.

---
 rtl/vl6180x_i2c_master.sv | 196 +++++++++++++++++++
 tb/tb_vl6180x_i2c_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vl6180x_i2c_master.sv
// Byte-level I2C master for VL6180X register accesses (16-bit index, 8-bit data).
// SCL/SDA are open-drain: an output of 1 pulls the line low, 0 releases it.
module vl6180x_i2c_master #(
    parameter int         QUARTER  = 30,
    parameter logic [6:0] DEV_ADDR = 7'h29
) (
    input  logic        CLK_12M,
    input  logic        RST_N,
    input  logic        START,
    input  logic        RW,
    input  logic [15:0] INDEX,
    input  logic [7:0]  WDATA,
    output logic [7:0]  RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        NACK,
    output logic        SCL_OE,
    output logic        SDA_OE,
    input  logic        SDA_IN
);
    localparam int            QW    = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TXBYTE,
        ST_RXBYTE,
        ST_RESTART,
        ST_STOP,
        ST_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          first_q, rw_q, busy_q, done_q, nack_q, scl_q, sda_q;
    logic          scl_d, sda_d;
    logic [15:0]   index_q;
    logic [7:0]    wdata_q, rx_q, rdata_q, txByte;
    logic          accept, active, tick, sample, slotEnd;

    assign accept  = START && !busy_q;
    // The cycle right after accept is a lead-in; quarter counting starts one edge later.
    assign active  = busy_q && !first_q;
    assign tick    = active && (qcnt_q == QLAST);
    assign sample  = tick && (phase_q == 2'd2);
    assign slotEnd = tick && (phase_q == 2'd3);

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        if (accept) begin
            state_d = ST_START;
            qcnt_d  = '0;
            phase_d = 2'd0;
            bit_d   = 4'd0;
            byte_d  = 2'd0;
        end else if (state_q == ST_FINISH) begin
            state_d = ST_IDLE;
        end else if (active) begin
            qcnt_d  = tick ? '0 : qcnt_q + QW'(1);
            phase_d = tick ? phase_q + 2'd1 : phase_q;
            if (slotEnd) begin
                case (state_q)
                    ST_START: begin
                        state_d = ST_TXBYTE;
                        bit_d   = 4'd0;
                        byte_d  = 2'd0;
                    end
                    ST_TXBYTE: begin
                        if (bit_q != 4'd8) begin
                            bit_d = bit_q + 4'd1;
                        end else begin
                            bit_d  = 4'd0;
                            byte_d = byte_q + 2'd1;
                            if (nack_q)
                                state_d = ST_STOP;
                            else if (byte_q == 2'd2 && rw_q)
                                state_d = ST_RESTART;
                            else if (byte_q == 2'd3)
                                state_d = rw_q ? ST_RXBYTE : ST_STOP;
                        end
                    end
                    ST_RXBYTE: begin
                        if (bit_q != 4'd8)
                            bit_d = bit_q + 4'd1;
                        else
                            state_d = ST_STOP;
                    end
                    ST_RESTART: begin
                        state_d = ST_TXBYTE;
                        bit_d   = 4'd0;
                    end
                    ST_STOP:  state_d = ST_FINISH;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (byte_d)
            2'd0:    txByte = {DEV_ADDR, 1'b0};
            2'd1:    txByte = index_q[15:8];
            2'd2:    txByte = index_q[7:0];
            default: txByte = rw_q ? {DEV_ADDR, 1'b1} : wdata_q;
        endcase
    end

    // Line levels are decoded from the next position so the pins come straight from flops.
    always_comb begin
        scl_d = 1'b0;
        sda_d = 1'b0;
        case (state_d)
            ST_START: begin
                scl_d = (phase_d == 2'd3);
                sda_d = (phase_d != 2'd0);
            end
            ST_TXBYTE: begin
                scl_d = (phase_d < 2'd2);
                sda_d = !bit_d[3] && !txByte[~bit_d[2:0]];
            end
            ST_RXBYTE:  scl_d = (phase_d < 2'd2);
            ST_RESTART: begin
                scl_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_d = (phase_d >= 2'd2);
            end
            ST_STOP: begin
                scl_d = (phase_d == 2'd0);
                sda_d = (phase_d < 2'd2);
            end
            default: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_12M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            qcnt_q  <= '0;
            phase_q <= 2'd0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            first_q <= 1'b0;
            rw_q    <= 1'b0;
            index_q <= 16'h0000;
            wdata_q <= 8'h00;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            first_q <= accept;
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_FINISH);
            done_q  <= (state_d == ST_FINISH);
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            if (accept) begin
                rw_q    <= RW;
                index_q <= INDEX;
                wdata_q <= WDATA;
                nack_q  <= 1'b0;
            end else if (sample && state_q == ST_TXBYTE && bit_q == 4'd8 && SDA_IN) begin
                nack_q  <= 1'b1;
            end
            if (sample && state_q == ST_RXBYTE && !bit_q[3])
                rx_q <= {rx_q[6:0], SDA_IN};
            if (slotEnd && state_q == ST_RXBYTE && bit_q[3])
                rdata_q <= rx_q;
        end
    end

    assign RDATA  = rdata_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign NACK   = nack_q;
    assign SCL_OE = scl_q;
    assign SDA_OE = sda_q;

endmodule

// File: tb/tb_vl6180x_i2c_master.sv
// Bench for vl6180x_i2c_master: a register-file slave on the bus plus a transaction-level
// reference model (expected bytes, latency from the quarter budget, memory contents).
module tb_vl6180x_i2c_master;
    localparam int Q = 30;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] index = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        busy, done, nack, sclOe, sdaOe, sdaIn;
    logic        slaveLow;

    assign sdaIn = !sdaOe && !slaveLow;

    vl6180x_i2c_master #(.QUARTER(Q), .DEV_ADDR(7'h29)) dut (
        .CLK_12M(clk),
        .RST_N  (rstN),
        .START  (start),
        .RW     (rw),
        .INDEX  (index),
        .WDATA  (wdata),
        .RDATA  (rdata),
        .BUSY   (busy),
        .DONE   (done),
        .NACK   (nack),
        .SCL_OE (sclOe),
        .SDA_OE (sdaOe),
        .SDA_IN (sdaIn)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] refMem   [0:65535];
    logic [7:0] slaveMem [0:65535];
    logic [7:0] rdataExp = 8'h00;
    logic       nackAddr = 1'b0;
    logic [7:0] seenBytes [$];
    int         sCount = 0, pCount = 0, masterNacks = 0, doneCount = 0;

    function automatic logic [7:0] memInit(input logic [15:0] a);
        return 8'hB4 ^ (a[7:0] * 8'd7) ^ a[15:8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Bus-side slave and monitor: decodes bytes on SCL rising, drives acks/read data on SCL falling.
    initial begin : busMonitor
        logic       prevScl, prevSda, scl, sda, txMode, ackNext, readMode;
        int         bitCnt, byteNum;
        logic [7:0] shiftIn, txByte;
        logic [15:0] regAddr;
        for (int i = 0; i < 65536; i++) slaveMem[i] = memInit(16'(i));
        slaveLow = 1'b0;
        prevScl = 1'b1; prevSda = 1'b1; txMode = 1'b0; ackNext = 1'b0; readMode = 1'b0;
        bitCnt = 0; byteNum = 0; shiftIn = 8'h00; txByte = 8'h00; regAddr = 16'h0000;
        forever begin
            @(negedge clk);
            if (done) doneCount++;
            scl = !sclOe;
            sda = sdaIn;
            if (!rstN) begin
                bitCnt = 0; txMode = 1'b0; slaveLow = 1'b0;
            end else if (prevScl && scl && prevSda && !sda) begin
                sCount++; bitCnt = 0; byteNum = 0; txMode = 1'b0; slaveLow = 1'b0;
            end else if (prevScl && scl && !prevSda && sda) begin
                pCount++; txMode = 1'b0; slaveLow = 1'b0;
            end else if (!prevScl && scl) begin
                if (bitCnt < 8) begin
                    shiftIn = {shiftIn[6:0], sda};
                    bitCnt++;
                    if (bitCnt == 8) begin
                        seenBytes.push_back(shiftIn);
                        if (!txMode) begin
                            if (byteNum == 0) begin
                                ackNext  = (shiftIn[7:1] == 7'h29) && !nackAddr;
                                readMode = shiftIn[0];
                            end else begin
                                ackNext = 1'b1;
                                if (byteNum == 1)      regAddr[15:8] = shiftIn;
                                else if (byteNum == 2) regAddr[7:0]  = shiftIn;
                                else                   slaveMem[regAddr] = shiftIn;
                            end
                        end
                    end
                end else begin
                    bitCnt = 0;
                    if (txMode) begin
                        if (sda) masterNacks++;
                        txMode = 1'b0;
                    end else begin
                        if (byteNum == 0 && ackNext && readMode) begin
                            txMode = 1'b1;
                            txByte = slaveMem[regAddr];
                        end
                        byteNum++;
                    end
                end
            end else if (prevScl && !scl) begin
                if (txMode && bitCnt < 8)       slaveLow = !txByte[7 - bitCnt];
                else if (!txMode && bitCnt == 8) slaveLow = ackNext;
                else                             slaveLow = 1'b0;
            end
            prevScl = scl;
            prevSda = !sdaOe && !slaveLow;
        end
    end

    task automatic applyStimulus(input string tag, input logic rwIn, input logic [15:0] idx,
                                 input logic [7:0] wd, input logic nackA, input logic holdStart);
        int         s0, p0, b0, d0, m0, k, quarters;
        logic       got, glitch;
        logic [7:0] expData;
        logic [7:0] expBytes [$];
        s0 = sCount; p0 = pCount; b0 = seenBytes.size(); d0 = doneCount; m0 = masterNacks;
        expData  = refMem[idx];
        quarters = nackA ? 8 + 36 : (rwIn ? 8 + 36 * 5 + 4 : 8 + 36 * 4);
        expBytes = {8'h52};
        if (!nackA) begin
            expBytes.push_back(idx[15:8]);
            expBytes.push_back(idx[7:0]);
            if (rwIn) begin
                expBytes.push_back(8'h53);
                expBytes.push_back(expData);
            end else begin
                expBytes.push_back(wd);
            end
        end
        nackAddr = nackA;
        @(negedge clk);
        start = 1'b1; rw = rwIn; index = idx; wdata = wd;
        @(posedge clk); #1;
        k = cycle;
        checkOutput({tag, " busyAtAccept"}, 32'(busy), 32'd1);
        checkOutput({tag, " nackAtAccept"}, 32'(nack), 32'd0);
        got = 1'b0; glitch = 1'b0;
        for (int i = 0; i < 9000 && !got; i++) begin
            @(negedge clk);
            start = holdStart; rw = 1'($urandom); index = 16'($urandom); wdata = 8'($urandom);
            @(posedge clk); #1;
            if (done) got = 1'b1;
            else if (!busy) glitch = 1'b1;
        end
        start = 1'b0;
        checkOutput({tag, " doneSeen"}, 32'(got), 32'd1);
        checkOutput({tag, " doneLatency"}, 32'(cycle - k), 32'(1 + Q * quarters));
        checkOutput({tag, " busyGlitch"}, 32'(glitch), 32'd0);
        checkOutput({tag, " busyAtDone"}, 32'(busy), 32'd0);
        checkOutput({tag, " nack"}, 32'(nack), 32'(nackA));
        if (rwIn && !nackA) rdataExp = expData;
        if (!rwIn && !nackA) refMem[idx] = wd;
        checkOutput({tag, " rdata"}, 32'(rdata), 32'(rdataExp));
        @(posedge clk); #1;
        checkOutput({tag, " busyAfter"}, 32'(busy), 32'd0);
        checkOutput({tag, " doneAfter"}, 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput({tag, " byteCount"}, 32'(seenBytes.size() - b0), 32'(expBytes.size()));
        for (int i = 0; i < expBytes.size() && b0 + i < seenBytes.size(); i++)
            checkOutput($sformatf("%s byte%0d", tag, i), 32'(seenBytes[b0 + i]), 32'(expBytes[i]));
        checkOutput({tag, " startConds"}, 32'(sCount - s0), (rwIn && !nackA) ? 32'd2 : 32'd1);
        checkOutput({tag, " stopConds"}, 32'(pCount - p0), 32'd1);
        checkOutput({tag, " masterNack"}, 32'(masterNacks - m0), (rwIn && !nackA) ? 32'd1 : 32'd0);
        checkOutput({tag, " donePulses"}, 32'(doneCount - d0), 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) refMem[i] = memInit(16'(i));
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset sclOe", 32'(sclOe), 32'd0);
        checkOutput("reset sdaOe", 32'(sdaOe), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset nack", 32'(nack), 32'd0);
        checkOutput("reset rdata", 32'(rdata), 32'h00);
        @(negedge clk) rstN = 1'b1;
        @(negedge clk);

        applyStimulus("wr0018", 1'b0, 16'h0018, 8'h01, 1'b0, 1'b0);
        applyStimulus("rd0000", 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        applyStimulus("rd0062nack", 1'b1, 16'h0062, 8'h00, 1'b1, 1'b0);
        applyStimulus("wrHoldStart", 1'b0, 16'h1234, 8'hC3, 1'b0, 1'b1);

        // Abort in the middle of the address byte, then confirm a clean restart.
        @(negedge clk);
        nackAddr = 1'b0;
        start = 1'b1; rw = 1'b0; index = 16'h00AB; wdata = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("preReset busy", 32'(busy), 32'd1);
        checkOutput("preReset sdaOe", 32'(sdaOe), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midReset sclOe", 32'(sclOe), 32'd0);
        checkOutput("midReset sdaOe", 32'(sdaOe), 32'd0);
        checkOutput("midReset busy", 32'(busy), 32'd0);
        checkOutput("midReset done", 32'(done), 32'd0);
        checkOutput("midReset nack", 32'(nack), 32'd0);
        checkOutput("midReset rdata", 32'(rdata), 32'h00);
        rdataExp = 8'h00;
        @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        @(negedge clk);
        applyStimulus("postReset", 1'b0, 16'h00AB, 8'h77, 1'b0, 1'b0);

        applyStimulus("wr0016", 1'b0, 16'h0016, 8'h5A, 1'b0, 1'b0);
        applyStimulus("rd0016", 1'b1, 16'h0016, 8'h00, 1'b0, 1'b0);

        for (int t = 0; t < 8; t++)
            applyStimulus($sformatf("rand%0d", t), 1'($urandom), 16'($urandom), 8'($urandom),
                          ($urandom_range(0, 4) == 0), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
